// File: rtl/fr_ingr_req_responder.sv
// -----------------------------------------------------------------------------
// fr_ingr_req_responder
//
// Responder side of the ingress req/resp/data protocol. Source words are
// buffered in an internal first-word-fall-through FIFO. Each accepted read
// request is answered with one resp beat carrying a granted length (never more
// than requested, never more than what is buffered), followed by exactly that
// many bytes on the data channel.
//
// Ports:
//   ap_clk, ap_rst              clock, asynchronous active-high reset
//   in_tvalid/in_tready/in_tdata        32-bit source stream into the FIFO
//   req_tvalid/req_tready/req_tdata     64-bit request
//                                       ([63:48] len, [39:32] ch, [1] eof, [0] sof)
//   resp_tvalid/resp_tready/resp_tdata  64-bit response, same layout as req
//   data_tvalid/data_tready/data_tdata  32-bit burst data
//   req_error                   sticky: an illegal request was seen
//
// Optional build macro FR_INGR_REQ_RESPONDER_STATS_EN adds saturating
// counters stat_req_count, stat_short_count and stat_byte_count.
// -----------------------------------------------------------------------------
module fr_ingr_req_responder #(
   parameter int FIFO_DEPTH = 512,
   parameter int MAX_BURST  = 4096
) (
   input  logic        ap_clk,
   input  logic        ap_rst,
   input  logic        in_tvalid,
   output logic        in_tready,
   input  logic [31:0] in_tdata,
   input  logic        req_tvalid,
   output logic        req_tready,
   input  logic [63:0] req_tdata,
   output logic        resp_tvalid,
   input  logic        resp_tready,
   output logic [63:0] resp_tdata,
   output logic        data_tvalid,
   input  logic        data_tready,
   output logic [31:0] data_tdata,
   output logic        req_error
`ifdef FR_INGR_REQ_RESPONDER_STATS_EN
   ,
   output logic [31:0] stat_req_count,
   output logic [31:0] stat_short_count,
   output logic [31:0] stat_byte_count
`endif
);

   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [31:0] MAXB_C  = 32'(MAX_BURST);

   typedef enum logic [1:0] {S_IDLE, S_RESP, S_DATA} state_t;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   occ;
   state_t        state;
   logic [63:0]   resp_r;
   logic [13:0]   rem_words;
   logic          push;
   logic          pop;
   logic [15:0]   grant_c;
   logic          legal_c;
   logic          unused_req_bits;

   function automatic logic is_legal(input logic [15:0] len);
      return (len != 16'h0) && (len[1:0] == 2'b00) && ({16'h0, len} <= MAXB_C);
   endfunction

   // min(len, buffered bytes) for legal requests, 0 otherwise. When the
   // buffered byte count is below len it is below 2^16, so truncation is safe.
   function automatic logic [15:0] calc_grant(input logic [15:0] len,
                                              input logic [AW:0] occ_words);
      logic [31:0] occ_b;
      occ_b = 32'(occ_words) << 2;
      if (!is_legal(len))
         return 16'h0;
      return ({16'h0, len} <= occ_b) ? len : occ_b[15:0];
   endfunction

`ifdef FR_INGR_REQ_RESPONDER_STATS_EN
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   logic [15:0] req_len;
`endif

   assign unused_req_bits = ^{req_tdata[47:40], req_tdata[31:2]};

   // Handshake outputs decode the registered state; the ready outputs are
   // also gated by reset so they read 0 while reset is held and 1 right after.
   assign in_tready   = ~ap_rst & (occ != DEPTH_C);
   assign req_tready  = ~ap_rst & (state == S_IDLE);
   assign resp_tvalid = (state == S_RESP);
   assign resp_tdata  = resp_tvalid ? resp_r : 64'h0;
   assign data_tvalid = (state == S_DATA);
   assign data_tdata  = data_tvalid ? mem[rd_ptr] : 32'h0;

   assign push    = in_tvalid & in_tready;
   assign pop     = data_tvalid & data_tready;
   assign grant_c = calc_grant(req_tdata[63:48], occ);
   assign legal_c = is_legal(req_tdata[63:48]);

   // FIFO storage (data only, no reset)
   always_ff @(posedge ap_clk) begin
      if (push)
         mem[wr_ptr] <= in_tdata;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Request / response / data FSM
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state     <= S_IDLE;
         resp_r    <= 64'h0;
         rem_words <= 14'h0;
         req_error <= 1'b0;
`ifdef FR_INGR_REQ_RESPONDER_STATS_EN
         req_len          <= 16'h0;
         stat_req_count   <= 32'h0;
         stat_short_count <= 32'h0;
         stat_byte_count  <= 32'h0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_tvalid) begin
                  resp_r <= {grant_c, 8'h0, req_tdata[39:32], 30'h0, req_tdata[1:0]};
                  if (!legal_c)
                     req_error <= 1'b1;
`ifdef FR_INGR_REQ_RESPONDER_STATS_EN
                  req_len <= req_tdata[63:48];
`endif
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_tready) begin
`ifdef FR_INGR_REQ_RESPONDER_STATS_EN
                  stat_req_count  <= sat_add(stat_req_count, 32'h1);
                  stat_byte_count <= sat_add(stat_byte_count, {16'h0, resp_r[63:48]});
                  if (resp_r[63:48] < req_len)
                     stat_short_count <= sat_add(stat_short_count, 32'h1);
`endif
                  if (resp_r[63:48] == 16'h0) begin
                     state <= S_IDLE;
                  end else begin
                     rem_words <= resp_r[63:50];
                     state     <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (data_tready) begin
                  rem_words <= rem_words - 14'd1;
                  if (rem_words == 14'd1)
                     state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fr_ingr_req_responder.sv
module tb_fr_ingr_req_responder;

   localparam int FD = 512;
   localparam int MB = 4096;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        in_tvalid = 1'b0;
   logic        in_tready;
   logic [31:0] in_tdata = 32'h0;
   logic        req_tvalid = 1'b0;
   logic        req_tready;
   logic [63:0] req_tdata = 64'h0;
   logic        resp_tvalid;
   logic        resp_tready;
   logic [63:0] resp_tdata;
   logic        data_tvalid;
   logic        data_tready;
   logic [31:0] data_tdata;
   logic        req_error;
`ifdef FR_INGR_REQ_RESPONDER_STATS_EN
   logic [31:0] stat_req_count;
   logic [31:0] stat_short_count;
   logic [31:0] stat_byte_count;
`endif

   fr_ingr_req_responder #(.FIFO_DEPTH(FD), .MAX_BURST(MB)) dut (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .in_tvalid   (in_tvalid),
      .in_tready   (in_tready),
      .in_tdata    (in_tdata),
      .req_tvalid  (req_tvalid),
      .req_tready  (req_tready),
      .req_tdata   (req_tdata),
      .resp_tvalid (resp_tvalid),
      .resp_tready (resp_tready),
      .resp_tdata  (resp_tdata),
      .data_tvalid (data_tvalid),
      .data_tready (data_tready),
      .data_tdata  (data_tdata),
      .req_error   (req_error)
`ifdef FR_INGR_REQ_RESPONDER_STATS_EN
      ,
      .stat_req_count   (stat_req_count),
      .stat_short_count (stat_short_count),
      .stat_byte_count  (stat_byte_count)
`endif
   );

   always #5 ap_clk = ~ap_clk;

   int tests = 0;
   int fails = 0;
   int data_beats = 0;
   int stall_cnt = 0;
   bit data_toggle = 1'b0;

   logic [63:0] exp_resp_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] model_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic push_words(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         in_tdata  = base + 32'(i);
         in_tvalid = 1'b1;
         check("in_tready_push", 64'(in_tready), 64'h1);
         tick();
         model_q.push_back(base + 32'(i));
      end
      in_tvalid = 1'b0;
   endtask

   // exp is the hand-computed response word; its length field gives the beats.
   task automatic do_req(input logic [15:0] len, input logic [7:0] ch,
                         input logic sof, input logic eof, input logic [63:0] exp);
      int n;
      n = 0;
      req_tdata  = {len, 8'hA5, ch, 30'h1555_5554, eof, sof};
      req_tvalid = 1'b1;
      while (!req_tready && n < 100) begin
         tick();
         n++;
      end
      if (!req_tready) begin
         tests++;
         fails++;
         $display("FAIL req_accept_timeout: got req_tready=0 expected 1");
      end
      exp_resp_q.push_back(exp);
      for (int i = 0; i < int'(exp[63:50]); i++)
         exp_data_q.push_back(model_q.pop_front());
      tick();
      req_tvalid = 1'b0;
      req_tdata  = 64'h0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_resp_q.size() != 0 || exp_data_q.size() != 0) && n < 300) begin
         tick();
         n++;
      end
      if (exp_resp_q.size() != 0 || exp_data_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d resp %0d data pending expected 0",
                  exp_resp_q.size(), exp_data_q.size());
      end
      tick();
      tick();
   endtask

   // Sink-side ready driver: optional resp stall and data_tready toggling.
   initial begin
      resp_tready = 1'b1;
      data_tready = 1'b1;
      forever begin
         @(posedge ap_clk);
         #1;
         if (resp_tvalid && stall_cnt > 0) begin
            resp_tready = 1'b0;
            stall_cnt--;
         end else begin
            resp_tready = 1'b1;
         end
         if (data_toggle)
            data_tready = ~data_tready;
         else
            data_tready = 1'b1;
      end
   end

   // Monitor: observes handshakes mid-cycle and pops the scoreboard.
   initial begin
      logic [63:0] held;
      bit          hold;
      bit          chk_idle;
      held = 64'h0;
      hold = 1'b0;
      chk_idle = 1'b0;
      forever begin
         @(negedge ap_clk);
         if (chk_idle) begin
            check("after_burst_data_tvalid", 64'(data_tvalid), 64'h0);
            check("after_burst_req_tready", 64'(req_tready), 64'h1);
            chk_idle = 1'b0;
         end
         if (resp_tvalid) begin
            if (hold)
               check("resp_stable", resp_tdata, held);
            if (resp_tready) begin
               hold = 1'b0;
               if (exp_resp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL resp_unexpected: got %h expected no response", resp_tdata);
               end else begin
                  check("resp_tdata", resp_tdata, exp_resp_q.pop_front());
               end
            end else begin
               hold = 1'b1;
               held = resp_tdata;
            end
         end else begin
            hold = 1'b0;
         end
         if (data_tvalid && data_tready) begin
            data_beats++;
            if (exp_data_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL data_unexpected: got %h expected no beat", data_tdata);
            end else begin
               check("data_tdata", 64'(data_tdata), 64'(exp_data_q.pop_front()));
               if (exp_data_q.size() == 0)
                  chk_idle = 1'b1;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      int n;

      // Reset values while reset is held
      tick();
      tick();
      check("rst_in_tready", 64'(in_tready), 64'h0);
      check("rst_req_tready", 64'(req_tready), 64'h0);
      check("rst_resp_tvalid", 64'(resp_tvalid), 64'h0);
      check("rst_resp_tdata", resp_tdata, 64'h0);
      check("rst_data_tvalid", 64'(data_tvalid), 64'h0);
      check("rst_data_tdata", 64'(data_tdata), 64'h0);
      check("rst_req_error", 64'(req_error), 64'h0);
      ap_rst = 1'b0;
      tick();
      check("post_rst_in_tready", 64'(in_tready), 64'h1);
      check("post_rst_req_tready", 64'(req_tready), 64'h1);

      // 1: full grant of 16 words
      push_words(32'h0, 16);
      do_req(16'd64, 8'd3, 1'b1, 1'b1, 64'h0040_0003_0000_0003);
      wait_drain();

      // 2: short grant limited by buffered data
      push_words(32'h100, 4);
      do_req(16'd32, 8'd1, 1'b1, 1'b0, 64'h0010_0001_0000_0001);
      wait_drain();
`ifdef FR_INGR_REQ_RESPONDER_STATS_EN
      check("stat_req_count", 64'(stat_req_count), 64'd2);
      check("stat_short_count", 64'(stat_short_count), 64'd1);
      check("stat_byte_count", 64'(stat_byte_count), 64'd80);
`endif

      // 3: empty FIFO, zero grant, next request two cycles after handshake
      base = data_beats;
      do_req(16'd8, 8'd2, 1'b0, 1'b1, 64'h0000_0002_0000_0002);
      check("zero_grant_busy", 64'(req_tready), 64'h0);
      tick();
      check("zero_grant_next_ready", 64'(req_tready), 64'h1);
      wait_drain();
      check("zero_grant_no_beats", 64'(data_beats - base), 64'h0);
      check("req_error_clear", 64'(req_error), 64'h0);

      // 4: illegal requests
      do_req(16'd6, 8'd5, 1'b1, 1'b1, 64'h0000_0005_0000_0003);
      check("req_error_set", 64'(req_error), 64'h1);
      wait_drain();
      do_req(16'(MB + 4), 8'd0, 1'b0, 1'b0, 64'h0000_0000_0000_0000);
      wait_drain();
      check("req_error_sticky", 64'(req_error), 64'h1);

      // 5: resp stalled 5 cycles, data_tready toggling
      push_words(32'h200, 8);
      base = data_beats;
      stall_cnt = 5;
      data_toggle = 1'b1;
      do_req(16'd32, 8'd7, 1'b0, 1'b0, 64'h0020_0007_0000_0000);
      wait_drain();
      data_toggle = 1'b0;
      tick();
      check("stall_beats", 64'(data_beats - base), 64'd8);
      do_req(16'd4, 8'h11, 1'b0, 1'b0, 64'h0000_0011_0000_0000);
      wait_drain();

      // 6: reset in the middle of a burst
      push_words(32'h300, 8);
      base = data_beats;
      do_req(16'd32, 8'd9, 1'b1, 1'b1, 64'h0020_0009_0000_0003);
      n = 0;
      while (data_beats < base + 3 && n < 100) begin
         tick();
         n++;
      end
      check("beats_before_reset", 64'(data_beats - base), 64'd3);
      ap_rst = 1'b1;
      #1;
      check("mid_rst_in_tready", 64'(in_tready), 64'h0);
      check("mid_rst_req_tready", 64'(req_tready), 64'h0);
      check("mid_rst_resp_tvalid", 64'(resp_tvalid), 64'h0);
      check("mid_rst_resp_tdata", resp_tdata, 64'h0);
      check("mid_rst_data_tvalid", 64'(data_tvalid), 64'h0);
      check("mid_rst_data_tdata", 64'(data_tdata), 64'h0);
      check("mid_rst_req_error", 64'(req_error), 64'h0);
      exp_data_q.delete();
      exp_resp_q.delete();
      model_q.delete();
      tick();
      ap_rst = 1'b0;
      tick();
      check("rerst_in_tready", 64'(in_tready), 64'h1);
      check("rerst_req_tready", 64'(req_tready), 64'h1);
      base = data_beats;
      do_req(16'd8, 8'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000);
      wait_drain();
      check("rerst_no_beats", 64'(data_beats - base), 64'h0);

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
